// File: rtl/mem_copy_engine.sv
// Word-block copy engine: drives the data-memory port to copy len words from srcAddr to dstAddr, one word per read/write pair.
// Optional COPY_CHECKSUM_EN adds a running modulo-2^DATA_WIDTH sum of the words written.
module mem_copy_engine #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] srcAddr,
    input  logic [ADDR_WIDTH-1:0] dstAddr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic [LEN_WIDTH-1:0]  count,
    output logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] writeData,
`ifdef COPY_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0] checksum,
`endif
    output logic                  memWrite,
    output logic                  memRead,
    input  logic [DATA_WIDTH-1:0] readData
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } copyStateT;

    copyStateT             state;
    copyStateT             nextState;
    logic [ADDR_WIDTH-1:0] srcBase;
    logic [ADDR_WIDTH-1:0] dstBase;
    logic [LEN_WIDTH-1:0]  lenReg;
    logic [DATA_WIDTH-1:0] dataBuf;
    logic [LEN_WIDTH-1:0]  countNext;
    logic                  lastWord;

    // Base plus word index, wrapping modulo 2^ADDR_WIDTH.
    function automatic logic [ADDR_WIDTH-1:0] offsetAddr(
        input logic [ADDR_WIDTH-1:0] base,
        input logic [LEN_WIDTH-1:0]  idx
    );
        logic [ADDR_WIDTH-1:0] ext;
        ext = ADDR_WIDTH'(idx);
        return base + ext;
    endfunction

    // The word index always equals the number of words written, so count doubles as idx.
    assign countNext = count + LEN_WIDTH'(1);
    assign lastWord  = (countNext == lenReg);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            srcBase  <= '0;
            dstBase  <= '0;
            lenReg   <= '0;
            count    <= '0;
            dataBuf  <= '0;
`ifdef COPY_CHECKSUM_EN
            checksum <= '0;
`endif
        end else begin
            state <= nextState;
            case (state)
                IDLE: begin
                    if (start) begin
                        srcBase  <= srcAddr;
                        dstBase  <= dstAddr;
                        lenReg   <= len;
                        count    <= '0;
`ifdef COPY_CHECKSUM_EN
                        checksum <= '0;
`endif
                    end
                end
                READ: begin
                    // An aborted read is dropped; the buffer keeps the last written word.
                    if (!abort) begin
                        dataBuf <= readData;
                    end
                end
                WRITE: begin
                    count    <= countNext;
`ifdef COPY_CHECKSUM_EN
                    checksum <= checksum + dataBuf;
`endif
                end
                default: begin
                end
            endcase
        end
    end

    always_comb begin
        nextState = state;
        busy      = 1'b0;
        done      = 1'b0;
        memRead   = 1'b0;
        memWrite  = 1'b0;
        address   = '0;
        writeData = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    nextState = (len != '0) ? READ : DONE;
                end
            end
            READ: begin
                busy      = 1'b1;
                memRead   = 1'b1;
                address   = offsetAddr(srcBase, count);
                nextState = abort ? DONE : WRITE;
            end
            WRITE: begin
                busy      = 1'b1;
                memWrite  = 1'b1;
                address   = offsetAddr(dstBase, count);
                writeData = dataBuf;
                nextState = (abort || lastWord) ? DONE : READ;
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_copy_engine.sv
// Scoreboard bench for mem_copy_engine: a word-level copy model predicts every memory cycle and done pulse.
module tb_mem_copy_engine;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] srcAddr;
    logic [31:0] dstAddr;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic [15:0] count;
    logic [31:0] address;
    logic [31:0] writeData;
    logic        memWrite;
    logic        memRead;
    logic [31:0] readData;
`ifdef COPY_CHECKSUM_EN
    logic [31:0] checksum;
`endif

    mem_copy_engine #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .srcAddr  (srcAddr),
        .dstAddr  (dstAddr),
        .len      (len),
        .busy     (busy),
        .done     (done),
        .count    (count),
        .address  (address),
        .writeData(writeData),
`ifdef COPY_CHECKSUM_EN
        .checksum (checksum),
`endif
        .memWrite (memWrite),
        .memRead  (memRead),
        .readData (readData)
    );

    always #5 clock = ~clock;

    // Small data memory: low 8 address bits select the word.
    logic [31:0] mem    [256];
    logic [31:0] refMem [256];
    logic        tbWe;
    logic [7:0]  tbAddr;
    logic [31:0] tbData;

    always @(posedge clock) begin
        if (memWrite) mem[address[7:0]] <= writeData;
        else if (tbWe) mem[tbAddr] <= tbData;
    end
    assign readData = memRead ? mem[address[7:0]] : 32'h0;

    int unsigned cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0]  kind;   // 0 read, 1 write, 2 done
        logic [31:0] when;
        logic [31:0] addr;
        logic [31:0] data;   // write data, or checksum for done
        logic [15:0] cnt;
    } evT;

    evT sb[$];
    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic pushEv(input logic [1:0] k, input logic [31:0] w, input logic [31:0] a,
                          input logic [31:0] d, input logic [15:0] c);
        evT e;
        e.kind = k; e.when = w; e.addr = a; e.data = d; e.cnt = c;
        sb.push_back(e);
    endtask

    // Monitor: every strobe or done pulse must match the head of the scoreboard.
    always @(negedge clock) begin : monitor
        evT e;
        logic [1:0] kAct;
        if (!reset) begin
            if (memRead || memWrite) chk("strobeExclusive", memRead & memWrite, 0);
            if (memRead || memWrite || done) begin
                kAct = memRead ? 2'd0 : (memWrite ? 2'd1 : 2'd2);
                chk("pendingExpect", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("evKind", kAct, e.kind);
                    chk("evCycle", cyc, e.when);
                    if (e.kind != 2'd2) begin
                        chk("evAddr", address, e.addr);
                        chk("busyActive", busy, 1);
                    end
                    if (e.kind == 2'd1) chk("evData", writeData, e.data);
                    if (e.kind == 2'd2) begin
                        chk("doneCount", count, e.cnt);
                        chk("busyInDone", busy, 0);
`ifdef COPY_CHECKSUM_EN
                        chk("doneChecksum", checksum, e.data);
`endif
                    end
                end
            end
        end
    end

    // All tasks below start and end at a negedge.
    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        tbWe = 1'b1; tbAddr = a; tbData = d;
        refMem[a] = d;
        @(negedge clock);
        tbWe = 1'b0;
    endtask

    task automatic memImage(input string nm);
        int mism;
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== refMem[i]) mism++;
        chk(nm, mism, 0);
    endtask

    task automatic doCopy(input logic [31:0] s, input logic [31:0] d, input logic [15:0] L,
                          input int abortCyc, input int ghostCyc);
        int n;
        bit extraRd;
        int doneRel;
        logic [31:0] sum;
        logic [31:0] t0;
        logic [31:0] ra;
        logic [31:0] wa;
        logic [31:0] w;
        if (L == 0) begin
            n = 0; extraRd = 0; doneRel = 1;
        end else if (abortCyc > 0 && abortCyc <= 2 * int'(L)) begin
            n = abortCyc / 2; extraRd = (abortCyc % 2) == 1; doneRel = abortCyc + 1;
        end else begin
            n = int'(L); extraRd = 0; doneRel = 2 * int'(L) + 1;
        end
        t0 = cyc;
        srcAddr = s; dstAddr = d; len = L; start = 1'b1;
        sum = 0;
        for (int k = 0; k < n; k++) begin
            ra = s + 32'(k);
            wa = d + 32'(k);
            w  = refMem[ra[7:0]];
            pushEv(2'd0, t0 + 32'(2 * k + 1), ra, 32'h0, 16'h0);
            pushEv(2'd1, t0 + 32'(2 * k + 2), wa, w, 16'h0);
            refMem[wa[7:0]] = w;
            sum = sum + w;
        end
        if (extraRd) pushEv(2'd0, t0 + 32'(2 * n + 1), s + 32'(n), 32'h0, 16'h0);
        pushEv(2'd2, t0 + 32'(doneRel), 32'h0, sum, 16'(n));
        for (int rel = 1; rel <= doneRel; rel++) begin
            @(negedge clock);
            start = (rel == ghostCyc);
            abort = (rel == abortCyc);
            if (rel == ghostCyc) begin
                srcAddr = s + 32'h40; dstAddr = d + 32'h3; len = L + 16'h1;
            end
        end
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
        chk("drained", sb.size(), 0);
        sb.delete();
        chk("countHeld", count, 16'(n));
        memImage("memImage");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] t0;
        logic [31:0] rs;
        logic [31:0] rd;
        logic [15:0] rl;
        int ab;
        int gh;
        reset = 1'b1; start = 1'b0; abort = 1'b0; tbWe = 1'b0; tbAddr = '0; tbData = '0;
        srcAddr = '0; dstAddr = '0; len = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rstBusy", busy, 0);
        chk("rstDone", done, 0);
        chk("rstMemRead", memRead, 0);
        chk("rstMemWrite", memWrite, 0);
        chk("rstAddress", address, 0);
        chk("rstWriteData", writeData, 0);
        chk("rstCount", count, 0);
`ifdef COPY_CHECKSUM_EN
        chk("rstChecksum", checksum, 0);
`endif
        reset = 1'b0;
        for (int i = 0; i < 256; i++) poke(8'(i), $urandom);

        poke(8'd6, 32'hFFFFFFFF);
        poke(8'd7, 32'hE0000000);
        doCopy(32'd6, 32'd20, 16'd2, 0, 0);
        chk("basicMem20", mem[20], 32'hFFFFFFFF);
        chk("basicMem21", mem[21], 32'hE0000000);

        doCopy(32'd40, 32'd50, 16'd0, 0, 0);
        doCopy(32'd8, 32'd60, 16'd4, 4, 0);
        doCopy(32'd70, 32'd90, 16'd3, 0, 2);

        // Reset in the middle of cycle 3 of a four-word copy.
        t0 = cyc;
        srcAddr = 32'd100; dstAddr = 32'd120; len = 16'd4; start = 1'b1;
        pushEv(2'd0, t0 + 1, 32'd100, 32'h0, 16'h0);
        pushEv(2'd1, t0 + 2, 32'd120, refMem[100], 16'h0);
        refMem[120] = refMem[100];
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("midRstBusy", busy, 0);
        chk("midRstDone", done, 0);
        chk("midRstMemRead", memRead, 0);
        chk("midRstMemWrite", memWrite, 0);
        chk("midRstAddress", address, 0);
        chk("midRstWriteData", writeData, 0);
        chk("midRstCount", count, 0);
        chk("midRstDrain", sb.size(), 0);
        sb.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        memImage("afterRstImage");
        doCopy(32'd100, 32'd120, 16'd4, 0, 0);

        doCopy(32'hFFFFFFFF, 32'd30, 16'd2, 0, 0);
        doCopy(32'd150, 32'd152, 16'd6, 0, 0);
        doCopy(32'd160, 32'd158, 16'd6, 0, 0);

        for (int t = 0; t < 30; t++) begin
            rs = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 200));
            rd = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 200));
            rl = 16'($urandom_range(0, 9));
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * int'(rl) + 1)) : 0;
            gh = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 * int'(rl) + 1)) : 0;
            doCopy(rs, rd, rl, ab, gh);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_copy_engine.md
# mem_copy_engine

Bus-initiator block that drives the word-addressed data-memory port (`address`, `writeData`, `memWrite`, `memRead`, `readData`) to copy a block of words from a source range to a destination range. It sits between a control source (CPU-side register block or testbench) and the `dataMemory` instance, owns that port while busy, and reports completion with a one-cycle `done` pulse. Transfers run one word per two clocks (read cycle, then write cycle).

## Interface
- `ADDR_WIDTH`, 32, width of word address
- `DATA_WIDTH`, 32, width of data word
- `LEN_WIDTH`, 16, width of transfer length / word counter

- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `abort`  in  1  stop after current memory cycle; sampled in READ/WRITE
- `srcAddr`  in  ADDR_WIDTH  first source word address, latched on accepted `start`
- `dstAddr`  in  ADDR_WIDTH  first destination word address, latched on accepted `start`
- `len`  in  LEN_WIDTH  number of words, latched on accepted `start`
- `busy`  out  1  high in READ and WRITE
- `done`  out  1  one-cycle pulse in DONE
- `count`  out  LEN_WIDTH  words written so far; held after completion until next accepted `start`
- `address`  out  ADDR_WIDTH  memory address
- `writeData`  out  DATA_WIDTH  memory write data
- `memWrite`  out  1  memory write strobe (memory commits on rising edge)
- `memRead`  out  1  memory read enable
- `readData`  in  DATA_WIDTH  memory read data, combinational from `address` while `memRead`=1

## Operation
- States: IDLE, READ, WRITE, DONE. Memory outputs are Moore-decoded from state and registers.
- IDLE: all memory outputs 0. `start`=1 at an edge → latch src/dst/len, clear `count` and index; go READ if `len`≠0, else DONE.
- READ: `memRead`=1, `address`=src+idx; at the edge, capture `readData` into the data buffer; go WRITE.
- WRITE: `memWrite`=1, `address`=dst+idx, `writeData`=buffer; at the edge, `count`+1, idx+1; go DONE if idx+1=len, else READ.
- DONE: `done`=1 for exactly one cycle; go IDLE.
- `abort`=1 at an edge in READ or WRITE → DONE. The memory cycle already driven in that cycle completes (a WRITE-state write commits and counts; a READ-state read is discarded).
- `start` outside IDLE is ignored, including in DONE.
- Address arithmetic is modulo 2^ADDR_WIDTH (wrap past all-ones to 0).
- Copy is forward (ascending index). Overlap with dst≤src copies correctly; overlap with dst>src propagates already-written words. This is defined behaviour, not an error.
- Reset (any time, async): state IDLE; `busy`, `done`, `memRead`, `memWrite` = 0; `address`, `writeData`, `count`, buffer = 0. Memory writes already committed remain.

## Timing
- Edge 0 samples `start`. Cycle n follows edge n.
- `len`=L>0: word k is READ in cycle 2k+1 and WRITE in cycle 2k+2; `done` high in cycle 2L+1; back in IDLE in cycle 2L+2, where a new `start` is accepted.
- `len`=0: `done` high in cycle 1; no memory strobe asserted.
- `memRead` and `memWrite` are never high in the same cycle.
- `count` reaches L on the edge that ends the last WRITE; it is stable when `done` is high.

## Configuration
- `COPY_CHECKSUM_EN` defined: adds output `checksum` (DATA_WIDTH). It is cleared on accepted `start`. Each word written adds `writeData` modulo 2^DATA_WIDTH, updated on the same edge as `count`. It resets to 0 and is valid while `done` is high.
- Undefined: the port and logic are absent. All other behaviour is identical.

## Test plan
- Preload mem[6]=FFFFFFFF, mem[7]=E0000000; start src=6 dst=20 len=2. Required: reads at 6,7; writes at 20,21; `done` in cycle 5; `count`=2; mem[20]=FFFFFFFF, mem[21]=E0000000.
- start len=0 → `done` in cycle 1; `memRead`/`memWrite` never high; `count`=0.
- len=4, src=8, `abort` raised in cycle 4 (WRITE of word 1) → mem[dst], mem[dst+1] written, dst+2 untouched; `done` in cycle 5; `count`=2.
- Second `start` (different src) pulsed in cycle 2 of a len=3 copy → ignored; original transfer completes with `done` in cycle 7.
- `reset` asserted mid-cycle 3 of a len=4 copy → all outputs 0 immediately; first word already written remains; a fresh start after reset release performs a full copy.
- With `COPY_CHECKSUM_EN`, the first scenario → `checksum`=DFFFFFFF while `done` is high; src=FFFFFFFF len=2 wraps, so reads occur at FFFFFFFF then 00000000.
